// File: rtl/sprite_plotter_if.sv
// Plot-request and single-pixel write bundle between game logic and the plotter.
// master = requester / pixel consumer side, slave = the plotter itself.
interface sprite_plotter_if;
    logic       startPlot;
    logic [1:0] object;
    logic [7:0] newX;
    logic [6:0] newY;
    logic [7:0] oldX;
    logic [6:0] oldY;
    logic [7:0] sizeX;
    logic [6:0] sizeY;
    logic [7:0] vgaX;
    logic [6:0] vgaY;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    // startPlot is a one-cycle request taken only when idle; plot qualifies
    // vgaX/vgaY/colour on the same cycle, done pulses once per accepted request.
    modport master (
        output startPlot, object, newX, newY, oldX, oldY, sizeX, sizeY,
        input  vgaX, vgaY, colour, plot, busy, done
    );
    modport slave (
        input  startPlot, object, newX, newY, oldX, oldY, sizeX, sizeY,
        output vgaX, vgaY, colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// Erases an object's old rectangle, then draws its new one, one pixel per clock,
// into the VGA adapter's single-pixel write port with off-screen clipping.
module sprite_plotter #(
    parameter int         MAX_X         = 159,
    parameter int         MAX_Y         = 119,
    parameter logic [2:0] BG_COLOUR     = 3'b000,
    parameter logic [2:0] BALL_COLOUR   = 3'b111,
    parameter logic [2:0] PADDLE_COLOUR = 3'b010,
    parameter logic [2:0] BLOCK_COLOUR  = 3'b100
) (
    input  logic                   clk,
    input  logic                   reset,
    sprite_plotter_if.slave        bus,
    output logic [1:0]             dbg_state
);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] obj_q, obj_d;
    logic [7:0] new_x_q, new_x_d, old_x_q, old_x_d, size_x_q, size_x_d, xo_q, xo_d;
    logic [6:0] new_y_q, new_y_d, old_y_q, old_y_d, size_y_q, size_y_d, yo_q, yo_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       x_last, y_last;
    logic [2:0] obj_colour;

    always_comb begin
        case (obj_q)
            2'b00:   obj_colour = BALL_COLOUR;
            2'b01:   obj_colour = PADDLE_COLOUR;
            2'b10:   obj_colour = BLOCK_COLOUR;
            default: obj_colour = BG_COLOUR;
        endcase
    end

    // Sums are one bit wider than the screen coordinate so clipping sees overflow.
    always_comb begin
        base_x = (state_q == ERASE) ? old_x_q : new_x_q;
        base_y = (state_q == ERASE) ? old_y_q : new_y_q;
        sum_x  = {1'b0, base_x} + {1'b0, xo_q};
        sum_y  = {1'b0, base_y} + {1'b0, yo_q};
        x_last = (xo_q == size_x_q - 8'd1);
        y_last = (yo_q == size_y_q - 7'd1);
    end

    always_comb begin
        state_d  = state_q;
        obj_d    = obj_q;
        new_x_d  = new_x_q;
        new_y_d  = new_y_q;
        old_x_d  = old_x_q;
        old_y_d  = old_y_q;
        size_x_d = size_x_q;
        size_y_d = size_y_q;
        xo_d     = xo_q;
        yo_d     = yo_q;
        vga_x_d  = vga_x_q;
        vga_y_d  = vga_y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.startPlot && bus.object != 2'b11) begin
                    obj_d    = bus.object;
                    new_x_d  = bus.newX;
                    new_y_d  = bus.newY;
                    old_x_d  = bus.oldX;
                    old_y_d  = bus.oldY;
                    size_x_d = bus.sizeX;
                    size_y_d = bus.sizeY;
                    xo_d     = 8'd0;
                    yo_d     = 7'd0;
                    busy_d   = 1'b1;
                    // Both phases share one size, so an empty rectangle skips both.
                    state_d  = (bus.sizeX == 8'd0 || bus.sizeY == 7'd0) ? DONE : ERASE;
                end
            end
            ERASE, DRAW: begin
                vga_x_d  = sum_x[7:0];
                vga_y_d  = sum_y[6:0];
                colour_d = (state_q == ERASE) ? BG_COLOUR : obj_colour;
                plot_d   = (sum_x <= 9'(MAX_X)) && (sum_y <= 8'(MAX_Y));
                if (x_last) begin
                    xo_d = 8'd0;
                    if (y_last) begin
                        yo_d    = 7'd0;
                        state_d = (state_q == ERASE) ? DRAW : DONE;
                    end else begin
                        yo_d = yo_q + 7'd1;
                    end
                end else begin
                    xo_d = xo_q + 8'd1;
                end
            end
            DONE: begin
                // First DONE cycle raises done; the second returns to IDLE, so a
                // request presented while done is high is not taken.
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            obj_q    <= 2'b00;
            new_x_q  <= 8'd0;
            new_y_q  <= 7'd0;
            old_x_q  <= 8'd0;
            old_y_q  <= 7'd0;
            size_x_q <= 8'd0;
            size_y_q <= 7'd0;
            xo_q     <= 8'd0;
            yo_q     <= 7'd0;
            vga_x_q  <= 8'd0;
            vga_y_q  <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            obj_q    <= obj_d;
            new_x_q  <= new_x_d;
            new_y_q  <= new_y_d;
            old_x_q  <= old_x_d;
            old_y_q  <= old_y_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
            xo_q     <= xo_d;
            yo_q     <= yo_d;
            vga_x_q  <= vga_x_d;
            vga_y_q  <= vga_y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.vgaX   = vga_x_q;
    assign bus.vgaY   = vga_y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter: directed and random plot requests against a
// rectangle-scan reference model, with a queue-based pixel/done scoreboard.
module tb_sprite_plotter;
    localparam int W = 19;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  dbg_state;
    int unsigned cycle = 0;

    sprite_plotter_if bus();

    sprite_plotter dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // entry = {is_done, x[7:0], y[6:0], colour[2:0]}
    logic [W-1:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          pix_seen = 0;
    int          done_seen = 0;
    int unsigned done_cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] obj_colour(input logic [1:0] o);
        case (o)
            2'b00:   return 3'b111;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Reference: erase rectangle then draw rectangle, row-major, off-screen pixels dropped.
    task automatic model(input logic [1:0] obj, input int ox, input int oy,
                         input int nx, input int ny, input int sx, input int sy);
        logic [7:0] xv;
        logic [6:0] yv;
        for (int ph = 0; ph < 2; ph++) begin
            for (int r = 0; r < sy; r++) begin
                for (int c = 0; c < sx; c++) begin
                    int x;
                    int y;
                    x = (ph == 0 ? ox : nx) + c;
                    y = (ph == 0 ? oy : ny) + r;
                    if (x <= 159 && y <= 119) begin
                        xv = 8'(x);
                        yv = 7'(y);
                        exp_q.push_back({1'b0, xv, yv, (ph == 0) ? 3'b000 : obj_colour(obj)});
                    end
                end
            end
        end
        exp_q.push_back({1'b1, 18'd0});
    endtask

    // Monitor: every plot or done cycle consumes one expected entry.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset) begin
            if (bus.plot) begin
                pix_seen++;
                if (exp_q.size() == 0) check("unexpected_pixel", {13'd0, bus.vgaX, bus.vgaY, bus.colour}, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    check("pixel", {13'd0, 1'b0, bus.vgaX, bus.vgaY, bus.colour}, {13'd0, e});
                end
            end
            if (bus.done) begin
                done_seen++;
                done_cycle = cycle;
                if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("done_marker", {13'd0, e}, {13'd0, 1'b1, 18'd0});
                end
            end
        end
    end

    task automatic drive(input logic [1:0] obj, input int ox, input int oy,
                         input int nx, input int ny, input int sx, input int sy);
        bus.startPlot = 1'b1;
        bus.object    = obj;
        bus.oldX      = 8'(ox);
        bus.oldY      = 7'(oy);
        bus.newX      = 8'(nx);
        bus.newY      = 7'(ny);
        bus.sizeX     = 8'(sx);
        bus.sizeY     = 7'(sy);
    endtask

    task automatic scribble();
        bus.object = 2'($urandom_range(0, 2));
        bus.oldX   = 8'($urandom);
        bus.oldY   = 7'($urandom);
        bus.newX   = 8'($urandom);
        bus.newY   = 7'($urandom);
        bus.sizeX  = 8'($urandom_range(1, 9));
        bus.sizeY  = 7'($urandom_range(1, 9));
    endtask

    // Issue one accepted request, optionally poke a second startPlot mid-flight,
    // then check done latency and idle afterwards.
    task automatic issue(input logic [1:0] obj, input int ox, input int oy,
                         input int nx, input int ny, input int sx, input int sy,
                         input bit poke);
        int unsigned c0;
        int          d0;
        int          n;
        int          npix;
        npix = sx * sy;
        model(obj, ox, oy, nx, ny, sx, sy);
        d0 = done_seen;
        @(negedge clk);
        drive(obj, ox, oy, nx, ny, sx, sy);
        @(posedge clk);
        #1;
        c0 = cycle;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.startPlot = poke;
        scribble();
        if (poke) begin
            @(negedge clk);
            bus.startPlot = 1'b0;
        end
        n = 0;
        while (done_seen == d0 && n < 2 * npix + 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_seen == d0) check("done_timeout", 32'd0, 32'd1);
        else check("done_latency", done_cycle - c0, 32'(2 * npix + 1));
        repeat (4) @(negedge clk);
        #1;
        check("busy_idle", {31'd0, bus.busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
        check("one_done", done_seen - d0, 32'd1);
    endtask

    initial begin
        int d0;
        int p0;
        int n;
        reset         = 1'b1;
        bus.startPlot = 1'b0;
        bus.object    = 2'b00;
        bus.oldX      = 8'd0;
        bus.oldY      = 7'd0;
        bus.newX      = 8'd0;
        bus.newY      = 7'd0;
        bus.sizeX     = 8'd0;
        bus.sizeY     = 7'd0;
        #1;
        check("rst_plot", {31'd0, bus.plot}, 32'd0);
        check("rst_vgax", {24'd0, bus.vgaX}, 32'd0);
        check("rst_vgay", {25'd0, bus.vgaY}, 32'd0);
        check("rst_colour", {29'd0, bus.colour}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(2'b00, 51, 4, 52, 5, 2, 2, 1'b0);        // ball move
        issue(2'b01, 100, 2, 99, 2, 16, 1, 1'b0);      // paddle
        issue(2'b10, 150, 100, 158, 118, 4, 2, 1'b0);  // clipping at right/bottom
        issue(2'b00, 10, 10, 20, 20, 0, 3, 1'b0);      // zero width
        issue(2'b10, 30, 40, 31, 41, 3, 3, 1'b1);      // second request dropped

        // object 11 is ignored entirely
        d0 = done_seen;
        @(negedge clk);
        drive(2'b11, 5, 5, 6, 6, 2, 2);
        @(negedge clk);
        bus.startPlot = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("none_busy", {31'd0, bus.busy}, 32'd0);
        check("none_done", done_seen - d0, 32'd0);

        // reset mid-draw after 3 draw pixels
        model(2'b00, 60, 60, 61, 61, 2, 2);
        p0 = pix_seen;
        @(negedge clk);
        drive(2'b00, 60, 60, 61, 61, 2, 2);
        @(negedge clk);
        bus.startPlot = 1'b0;
        n = 0;
        while (pix_seen < p0 + 7 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reset_reach", pix_seen - p0, 32'd7);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_plot", {31'd0, bus.plot}, 32'd0);
        check("mid_rst_vga", {17'd0, bus.vgaX, bus.vgaY}, 32'd0);
        check("mid_rst_colour", {29'd0, bus.colour}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_idle", {30'd0, bus.busy, bus.plot}, 32'd0);
        issue(2'b01, 0, 0, 1, 1, 3, 2, 1'b0);

        // random requests across the whole coordinate range
        for (int i = 0; i < 25; i++) begin
            issue(2'($urandom_range(0, 2)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 10)), int'($urandom_range(0, 6)),
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
